pid_integrator_mc: RTL and testbench

Multi-channel, time-multiplexed integral accumulator for the PID controller datapath. Each run adds every channel's current error and subtracts its previous error, so the accumulator tracks the running sum. Channels share one adder, processed in index order with a start/done handshake. Accumulators are signed two's complement and can be optionally clamped symmetrically (anti-windup). It sits between the error-sampling stage and the PID output summer, one instance serving all supply rails.

---
 rtl/pid_integrator_mc_if.sv | 39 +++
 rtl/pid_integrator_mc.sv | 188 ++++++++++++++++++
 tb/tb_pid_integrator_mc.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pid_integrator_mc_if.sv
// pid_integrator_mc_if
//   Handshake/data bundle for the multi-channel PID integral accumulator.
//   master : error-sampling side (drives start, errors, clr, sat_limit)
//   slave  : pid_integrator_mc (drives int_out, sat_flag, busy, done)
//   Signals:
//     start      request a run
//     cur_error  NUM_CH x ERR_WIDTH current errors, ch n at [n*ERR_WIDTH +: ERR_WIDTH]
//     old_error  NUM_CH x ERR_WIDTH previous errors, same packing
//     clr        per-channel accumulator clear (idle only)
//     sat_limit  positive clamp magnitude (unsigned)
//     int_out    NUM_CH x ACC_WIDTH accumulators, ch n at [n*ACC_WIDTH +: ACC_WIDTH]
//     sat_flag   per-channel clamp-occurred flag for the last run
//     busy       run in progress
//     done       one-cycle completion pulse
interface pid_integrator_mc_if #(
  parameter int ERR_WIDTH = 13,
  parameter int ACC_WIDTH = 26,
  parameter int NUM_CH    = 2
);
  logic                          start;
  logic [NUM_CH*ERR_WIDTH-1:0]   cur_error;
  logic [NUM_CH*ERR_WIDTH-1:0]   old_error;
  logic [NUM_CH-1:0]             clr;
  logic [ACC_WIDTH-2:0]          sat_limit;
  logic [NUM_CH*ACC_WIDTH-1:0]   int_out;
  logic [NUM_CH-1:0]             sat_flag;
  logic                          busy;
  logic                          done;

  modport master (
    output start, cur_error, old_error, clr, sat_limit,
    input  int_out, sat_flag, busy, done
  );

  modport slave (
    input  start, cur_error, old_error, clr, sat_limit,
    output int_out, sat_flag, busy, done
  );
endinterface

// File: rtl/pid_integrator_mc.sv
// pid_integrator_mc
//   Time-multiplexed integral accumulator shared by NUM_CH channels. Each run
//   adds every channel's current error and subtracts its previous error using
//   one adder, channel by channel (ADD then SUB per channel).
//   Optional feature macro: INT_SAT_EN
//     defined   : every ADD/SUB result is clamped to [-L, +L], sat_flag records clamps
//     undefined : results wrap at ACC_WIDTH bits, sat_flag is 0, sat_limit unused
//   Ports:
//     clk  system clock, rising edge
//     rst  synchronous active-high reset (discards any run in progress)
//     bus  pid_integrator_mc_if.slave (start/errors/clr/sat_limit in,
//          int_out/sat_flag/busy/done out)
module pid_integrator_mc #(
  parameter int ERR_WIDTH = 13,
  parameter int ACC_WIDTH = 26,
  parameter int NUM_CH    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  pid_integrator_mc_if.slave   bus
);

  localparam int              CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [CH_W-1:0]              r_ch;
  logic signed [ERR_WIDTH-1:0]  r_cur [NUM_CH];
  logic signed [ERR_WIDTH-1:0]  r_old [NUM_CH];
  logic signed [ACC_WIDTH-1:0]  r_acc [NUM_CH];

  logic signed [ACC_WIDTH-1:0]  w_acc_sel;
  logic signed [ERR_WIDTH-1:0]  w_err_sel;
  logic signed [ACC_WIDTH-1:0]  w_res;
  logic [NUM_CH*ACC_WIDTH-1:0]  w_int_out;

`ifdef INT_SAT_EN
  logic [ACC_WIDTH-2:0]         r_lim;
  logic [NUM_CH-1:0]            r_sat;
  logic signed [ACC_WIDTH:0]    w_acc_ext;
  logic signed [ACC_WIDTH:0]    w_err_ext;
  logic signed [ACC_WIDTH:0]    w_sum;
  logic signed [ACC_WIDTH:0]    w_lim_pos;
  logic signed [ACC_WIDTH:0]    w_lim_neg;
  logic                         w_clamped;
`else
  logic signed [ACC_WIDTH-1:0]  w_err_ext;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_state_nxt = ADD;
      ADD:     w_state_nxt = SUB;
      SUB:     w_state_nxt = (r_ch == LAST_CH) ? DONE : ADD;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shared adder: ADD uses the latched current error, SUB the previous one
  // ---------------------------------------------------------------------------
  always_comb begin
    w_acc_sel = r_acc[r_ch];
    w_err_sel = (r_state == SUB) ? r_old[r_ch] : r_cur[r_ch];
  end

`ifdef INT_SAT_EN
  // sat_limit is ACC_WIDTH-1 bits wide, so it can never exceed 2^(ACC_WIDTH-1)-1;
  // zero-extending it is the full internal saturation of L.
  always_comb begin
    w_acc_ext = {w_acc_sel[ACC_WIDTH-1], w_acc_sel};
    w_err_ext = {{(ACC_WIDTH+1-ERR_WIDTH){w_err_sel[ERR_WIDTH-1]}}, w_err_sel};
    w_sum     = (r_state == SUB) ? (w_acc_ext - w_err_ext) : (w_acc_ext + w_err_ext);
    w_lim_pos = {2'b00, r_lim};
    w_lim_neg = -w_lim_pos;
    w_clamped = 1'b0;
    w_res     = w_sum[ACC_WIDTH-1:0];
    if (w_sum > w_lim_pos) begin
      w_res     = w_lim_pos[ACC_WIDTH-1:0];
      w_clamped = 1'b1;
    end else if (w_sum < w_lim_neg) begin
      w_res     = w_lim_neg[ACC_WIDTH-1:0];
      w_clamped = 1'b1;
    end
  end
`else
  // Wrapping an ACC_WIDTH+1-bit sum back to ACC_WIDTH bits equals doing the
  // arithmetic directly at ACC_WIDTH bits, so the extra bit is not built.
  always_comb begin
    w_err_ext = {{(ACC_WIDTH-ERR_WIDTH){w_err_sel[ERR_WIDTH-1]}}, w_err_sel};
    w_res     = (r_state == SUB) ? (w_acc_sel - w_err_ext) : (w_acc_sel + w_err_ext);
  end
`endif

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_acc[i] <= '0;
        r_cur[i] <= '0;
        r_old[i] <= '0;
      end
      r_ch  <= '0;
`ifdef INT_SAT_EN
      r_sat <= '0;
      r_lim <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          // clr lands before the first ADD reads the accumulator, so a clr
          // coincident with start makes the run begin from zero.
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (bus.clr[i]) r_acc[i] <= '0;
          end
          if (bus.start) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              r_cur[i] <= bus.cur_error[i*ERR_WIDTH +: ERR_WIDTH];
              r_old[i] <= bus.old_error[i*ERR_WIDTH +: ERR_WIDTH];
            end
            r_ch  <= '0;
`ifdef INT_SAT_EN
            r_lim <= bus.sat_limit;
            r_sat <= '0;
`endif
          end
        end
        ADD, SUB: begin
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (r_ch == CH_W'(i)) begin
              r_acc[i] <= w_res;
`ifdef INT_SAT_EN
              if (w_clamped) r_sat[i] <= 1'b1;
`endif
            end
          end
          if ((r_state == SUB) && (r_ch != LAST_CH)) begin
            r_ch <= r_ch + CH_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_int_out = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_int_out[i*ACC_WIDTH +: ACC_WIDTH] = r_acc[i];
    end
  end

  assign bus.int_out = w_int_out;
  assign bus.busy    = (r_state != IDLE);
  assign bus.done    = (r_state == DONE);
`ifdef INT_SAT_EN
  assign bus.sat_flag = r_sat;
`else
  assign bus.sat_flag = '0;
`endif

endmodule

// File: tb/tb_pid_integrator_mc.sv
module tb_pid_integrator_mc;

  localparam int EW  = 13;
  localparam int AW  = 26;
  localparam int NCH = 2;

  logic clk;
  logic rst;

  pid_integrator_mc_if #(.ERR_WIDTH(EW), .ACC_WIDTH(AW), .NUM_CH(NCH)) bus ();

  pid_integrator_mc #(.ERR_WIDTH(EW), .ACC_WIDTH(AW), .NUM_CH(NCH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------------------------------------------------------------------
  // Reference model: on each accepted start, the whole run is computed with
  // plain integer arithmetic and laid out as a per-cycle list of expected
  // outputs (pre-run value, then one entry per ADD/SUB step).
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [NCH*AW-1:0] io;
    logic [NCH-1:0]    sat;
    logic              busy;
    logic              done;
  } snap_t;

  longint     m_acc [NCH];
  logic [NCH-1:0] m_sat;
  longint     m_lim;
  longint     lc [NCH];
  longint     lo [NCH];
  snap_t      q [$];
  snap_t      e;
  bit         armed = 1'b0;

  function automatic longint f_step(input longint v, input longint lim, output bit cl);
    longint m;
    cl = 1'b0;
    m  = longint'(1) <<< AW;
`ifdef INT_SAT_EN
    if (v > lim) begin
      v = lim; cl = 1'b1;
    end else if (v < -lim) begin
      v = -lim; cl = 1'b1;
    end
`else
    v = v % m;
    if (v < 0) v = v + m;
    if (v >= m / 2) v = v - m;
`endif
    return v;
  endfunction

  function automatic longint err_of(input logic [NCH*EW-1:0] v, input int n);
    logic [EW-1:0] s;
    s = v[n*EW +: EW];
    return longint'($signed(s));
  endfunction

  function automatic snap_t mk(input bit b, input bit d);
    snap_t s;
    s.io = '0;
    for (int n = 0; n < NCH; n++) s.io[n*AW +: AW] = AW'(m_acc[n]);
    s.sat  = m_sat;
    s.busy = b;
    s.done = d;
    return s;
  endfunction

  initial begin
    for (int n = 0; n < NCH; n++) m_acc[n] = 0;
    m_sat = '0;
    m_lim = 0;
    e     = mk(1'b0, 1'b0);
  end

  always @(posedge clk) begin
    bit cl;
    armed = 1'b1;
    if (rst) begin
      for (int n = 0; n < NCH; n++) m_acc[n] = 0;
      m_sat = '0;
      q.delete();
      e = mk(1'b0, 1'b0);
    end else if (q.size() != 0) begin
      e = q.pop_front();
    end else if (e.busy) begin
      e = mk(1'b0, 1'b0);
    end else begin
      for (int n = 0; n < NCH; n++) if (bus.clr[n]) m_acc[n] = 0;
      if (bus.start) begin
        m_sat = '0;
        m_lim = longint'(bus.sat_limit);
        for (int n = 0; n < NCH; n++) begin
          lc[n] = err_of(bus.cur_error, n);
          lo[n] = err_of(bus.old_error, n);
        end
        q.push_back(mk(1'b1, 1'b0));
        for (int n = 0; n < NCH; n++) begin
          m_acc[n] = f_step(m_acc[n] + lc[n], m_lim, cl);
          if (cl) m_sat[n] = 1'b1;
          q.push_back(mk(1'b1, 1'b0));
          m_acc[n] = f_step(m_acc[n] - lo[n], m_lim, cl);
          if (cl) m_sat[n] = 1'b1;
          q.push_back(mk(1'b1, n == NCH - 1));
        end
        e = q.pop_front();
      end else begin
        e = mk(1'b0, 1'b0);
      end
    end
  end

  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      cmp("int_out",  64'(bus.int_out),  64'(e.io));
      cmp("sat_flag", 64'(bus.sat_flag), 64'(e.sat));
      cmp("busy",     64'(bus.busy),     64'(e.busy));
      cmp("done",     64'(bus.done),     64'(e.done));
    end
  end

  // ---------------------------------------------------------------------------
  // Hand-computed literal expectations
  // ---------------------------------------------------------------------------
  task automatic lit(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, got, exp);
    end
  endtask

  function automatic longint dut_int(input int n);
    logic [AW-1:0] s;
    s = bus.int_out[n*AW +: AW];
    return longint'($signed(s));
  endfunction

  task automatic set_err(input int c0, input int o0, input int c1, input int o1);
    bus.cur_error = {EW'(c1), EW'(c0)};
    bus.old_error = {EW'(o1), EW'(o0)};
  endtask

  // Issues one start in the current cycle and returns in the first idle cycle.
  task automatic run(input int c0, input int o0, input int c1, input int o1,
                     input logic [1:0] c);
    set_err(c0, o0, c1, o1);
    bus.clr   = c;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.clr   = '0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.clr       = '0;
    bus.sat_limit = (AW-1)'(1000);
    set_err(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    lit("reset_int0", dut_int(0), 0);
    lit("reset_int1", dut_int(1), 0);
    lit("reset_busy", longint'(bus.busy), 0);
    lit("reset_done", longint'(bus.done), 0);
    lit("reset_sat",  longint'(bus.sat_flag), 0);

    // Basic run with an ignored mid-run start/clr
    set_err(100, 40, -50, 0);
    bus.start = 1'b1;
    @(negedge clk);                        // T+1
    bus.start = 1'b0;
    @(negedge clk);                        // T+2
    lit("basic_add0", dut_int(0), 100);
    set_err(7, 0, 7, 0);
    bus.start = 1'b1;
    bus.clr   = 2'b11;
    @(negedge clk);                        // T+3
    bus.start = 1'b0;
    bus.clr   = '0;
    lit("basic_sub0", dut_int(0), 60);
    repeat (2) @(negedge clk);             // T+5
    lit("basic_done", longint'(bus.done), 1);
    lit("basic_int1", dut_int(1), -50);
    @(negedge clk);                        // T+6
    lit("ignored_int0", dut_int(0), 60);
    lit("ignored_int1", dut_int(1), -50);
    lit("idle_busy",    longint'(bus.busy), 0);

    // clr together with start restarts channel 0 from zero
    run(5, 0, 0, 0, 2'b01);
    lit("clr_start_int0", dut_int(0), 5);
    lit("clr_start_int1", dut_int(1), -50);

    // Reset in the middle of a run
    set_err(3, 0, 0, 0);
    bus.start = 1'b1;
    @(negedge clk);                        // T+1
    bus.start = 1'b0;
    @(negedge clk);                        // T+2
    rst = 1'b1;
    @(negedge clk);                        // T+3
    rst = 1'b0;
    lit("midrst_int0", dut_int(0), 0);
    lit("midrst_int1", dut_int(1), 0);
    lit("midrst_busy", longint'(bus.busy), 0);
    lit("midrst_done", longint'(bus.done), 0);

    // start held high: accepted every 6 cycles, 3 runs in 13 cycles
    set_err(1, 0, -1, 0);
    bus.start = 1'b1;
    repeat (13) @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    lit("b2b_int0", dut_int(0), 3);
    lit("b2b_int1", dut_int(1), -3);

`ifdef INT_SAT_EN
    run(990, 0, -990, 0, 2'b11);
    lit("pre_clamp_int0", dut_int(0), 990);
    lit("pre_clamp_int1", dut_int(1), -990);
    run(50, 0, -50, 0, 2'b00);
    lit("clamp_hi_int0", dut_int(0), 1000);
    lit("clamp_lo_int1", dut_int(1), -1000);
    lit("clamp_sat",     longint'(bus.sat_flag), 3);
    run(0, 0, 0, 0, 2'b00);
    lit("sat_cleared",   longint'(bus.sat_flag), 0);
    lit("hold_int0",     dut_int(0), 1000);
    run(-10, 0, 0, 0, 2'b00);
    lit("back_to_990",   dut_int(0), 990);
    // Per-step clamp: 990+50 -> 1000, then 1000-40 -> 960
    set_err(50, 40, 0, 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);                        // T+2
    lit("step_add0", dut_int(0), 1000);
    @(negedge clk);                        // T+3
    lit("step_sub0", dut_int(0), 960);
    repeat (3) @(negedge clk);             // T+6
    lit("step_sat",  longint'(bus.sat_flag), 1);
    // L=0 forces both accumulators to zero
    bus.sat_limit = '0;
    run(5, 0, 0, 0, 2'b00);
    lit("l0_int0", dut_int(0), 0);
    lit("l0_int1", dut_int(1), 0);
    lit("l0_sat",  longint'(bus.sat_flag), 3);
`else
    // 4096 back-to-back runs of +8191 on ch0, from 3
    set_err(4095, -4096, 0, 0);
    bus.start = 1'b1;
    repeat (4095 * 6 + 1) @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    lit("wrap_ramp_int0", dut_int(0), 33550339);
    run(4092, 0, 0, 0, 2'b00);
    lit("wrap_max_int0", dut_int(0), 33554431);
    set_err(1, 0, 0, 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);                        // T+2
    lit("wrap_int0", dut_int(0), -33554432);
    lit("wrap_sat",  longint'(bus.sat_flag), 0);
    repeat (4) @(negedge clk);
    lit("wrap_final_int0", dut_int(0), -33554432);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
